// File: rtl/alu_cmd_sequencer.sv
// Command sequencer around a combinational ALU: latches a command, issues registered
// operands, captures the result one cycle later and writes it back to a small register file.
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              done,
  output logic              carry_flag
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WB} state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   src_a_q, src_b_q, dst_q;
  logic                imm_en_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   alu_a_q, alu_b_q, res_q;
  logic [OP_W-1:0]     alu_op_q;
  logic                carry_q, carry_flag_q, done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ISSUE;
      ISSUE:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: blocking assignments in combinational logic; the writeback is assigned last so it
  // overrides a host write to the same register on the WB edge.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
    if (state_q == WB) regs_d[dst_q] = res_q;
  end

  // NOTE: sequential state uses non-blocking assignments only. The register file is small and
  // must read as zero after reset, so it is reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      done_q       <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      done_q  <= (state_q == WB);
      if (state_q == WB) carry_flag_q <= carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      dst_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        src_a_q  <= cmd_src_a;
        src_b_q  <= cmd_src_b;
        imm_en_q <= cmd_imm_en;
        imm_q    <= cmd_imm;
        dst_q    <= cmd_dst;
      end
      // Operands come from regs_q, so a host write on this same edge is not observed.
      if (state_q == ISSUE) begin
        alu_a_q  <= regs_q[src_a_q];
        alu_b_q  <= imm_en_q ? imm_q : regs_q[src_b_q];
        alu_op_q <= op_q;
      end
      if (state_q == EXEC) begin
        res_q   <= alu_result;
        carry_q <= alu_carry;
      end
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rd_data    = regs_q[rd_addr];
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign done       = done_q;
  assign carry_flag = carry_flag_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-driven operand sequencer and writeback stage that sits directly upstream and downstream of the combinational 8-bit ALU.
- Holds a small register file and accepts one ALU command per handshake.
- Drives registered operand_a/operand_b/operation into the ALU, then captures result and carry_out.
- Writes the result back to a destination register and pulses done; a host port preloads and reads registers.

Parameters:
DATA_W, 8, operand/result width (matches ALU)
OP_W, 4, ALU operation code width
ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  OP_W  ALU operation to issue
cmd_src_a  input  ADDR_W  register supplying operand_a
cmd_src_b  input  ADDR_W  register supplying operand_b (ignored when cmd_imm_en=1)
cmd_imm_en  input  1  1: operand_b = cmd_imm
cmd_imm  input  DATA_W  immediate operand_b
cmd_dst  input  ADDR_W  destination register for result
wr_en  input  1  host register write strobe
wr_addr  input  ADDR_W  host write address
wr_data  input  DATA_W  host write data
rd_addr  input  ADDR_W  host read address
rd_data  output  DATA_W  combinational read of regs[rd_addr]
alu_a  output  DATA_W  to ALU operand_a (registered)
alu_b  output  DATA_W  to ALU operand_b (registered)
alu_op  output  OP_W  to ALU operation (registered)
alu_result  input  DATA_W  from ALU result
alu_carry  input  1  from ALU carry_out
done  output  1  one-cycle pulse after writeback
carry_flag  output  1  carry captured from the last completed command

Behaviour:
- Reset (async, immediate): all regs=0; alu_a/alu_b/alu_op=0; done=0; carry_flag=0; state=IDLE; cmd_ready=1 once state is IDLE. In-flight command is discarded with no done pulse and no writeback.
- FSM states: IDLE, ISSUE, EXEC, WB. cmd_ready=1 only in IDLE, driven from state with no combinational path from cmd_valid.
- Edge E0, IDLE: if cmd_valid, latch op/src_a/src_b/imm_en/imm/dst and go to ISSUE. Otherwise stay in IDLE.
- Edge E1, ISSUE: alu_a<=regs[src_a]; alu_b<=imm_en?imm:regs[src_b]; alu_op<=op; go to EXEC. Operands are the register values before this edge; a host write landing on E1 is not seen.
- Edge E2, EXEC: ALU inputs have been stable one full cycle. res_q<=alu_result; carry_q<=alu_carry; go to WB.
- Edge E3, WB: regs[dst]<=res_q; carry_flag<=carry_q; done<=1; go to IDLE.
- done is high for exactly the cycle after E3 and is cleared at the next edge.
- Throughput: one command per 4 cycles. A back-to-back command is accepted at E4 and reads at E5, so it always sees the previous writeback and there is no hazard.
- alu_a/alu_b/alu_op hold their last values outside ISSUE; they are not zeroed.
- Host write (wr_en): writes regs[wr_addr] at the edge in any state.
  - Same edge as WB and wr_addr==dst: WB wins and the host write is dropped.
  - Different address: both writes take effect.
- src_a==src_b and dst==src are all legal.
- rd_data is combinational and reflects writes from the previous edge.
- carry_flag updates only at WB, for every op; the raw ALU carry_out is captured regardless of operation.
- Arithmetic: no width change; result is DATA_W, with overflow carried only via alu_carry.

Test Plan:
Bench stub ALU: result=(a+b) mod 256, carry=bit 8; the real ALU is swapped in for regression.
- Reset mid-EXEC: preload r0=8'h33, r1=8'hCC, issue op=4'h0 src_a=0 src_b=1 dst=2, assert rst in EXEC -> r2=0, done never pulses, cmd_ready=1 after rst release, carry_flag=0.
- Basic add: r0=8'h33, r1=8'hCC, cmd src_a=0 src_b=1 dst=2 op=4'h5 -> alu_op=4'h5 after E1, r2=8'hFF, carry_flag=0, done high exactly one cycle, 4 cycles after accept.
- Carry/immediate: r3=8'hF0, cmd src_a=3 imm_en=1 imm=8'h20 dst=3 -> r3=8'h10, carry_flag=1.
- Back-to-back dependency: cmd1 r0+r1->r2 (8'h01+8'h02), cmd_valid held high, cmd2 r2+r2->r0 -> cmd_ready low during ISSUE/EXEC/WB, cmd2 accepted the cycle done pulses, r0=8'h06.
- Write collision: during WB of cmd dst=1 (result 8'hAA) drive wr_en addr=1 data=8'h55 -> r1=8'hAA. Repeat with addr=3 -> r1=8'hAA and r3=8'h55.
- Random soak: 1000 random commands and host writes against a reference model -> every done matches the model register file and carry_flag, and rd_data matches the model at all times.
